// File: rtl/bcd_mux_arb_if.sv
// bcd_mux_arb_if: request/data/grant bundle between three sources and the arbitrating mux
interface bcd_mux_arb_if;
  logic req_b, req_c, req_d;
  logic [7:0] b, c, d;
  logic gnt_b, gnt_c, gnt_d;
  logic s1, s2;
  logic [7:0] out;
  logic out_valid, busy;
  modport master (
    output req_b, req_c, req_d, b, c, d,
    input gnt_b, gnt_c, gnt_d, s1, s2, out, out_valid, busy
  );
  modport slave (
    input req_b, req_c, req_d, b, c, d,
    output gnt_b, gnt_c, gnt_d, s1, s2, out, out_valid, busy
  );
endinterface

// File: rtl/bcd_mux_arb.sv
// bcd_mux_arb: round-robin 3-source arbiter that captures the winner's byte and presents it for DWELL cycles
module bcd_mux_arb #(
  parameter int unsigned DWELL = 4
) (
  input logic clk,
  input logic rst,
  bcd_mux_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;
  state_t state, state_nx;
  logic [1:0] win, last, pick;
  logic [7:0] cnt, out_r, data;
  logic [2:0] r;
  logic any;
  assign r = {bus.req_d, bus.req_c, bus.req_b};
  assign any = |r;
  assign data = win == 2'd0 ? bus.b : win == 2'd1 ? bus.c : bus.d;
  // search begins at the source after the last one that reached HOLD
  always_comb begin
    pick = last == 2'd0 ? (r[1] ? 2'd1 : r[2] ? 2'd2 : 2'd0) :
           last == 2'd1 ? (r[2] ? 2'd2 : r[0] ? 2'd0 : 2'd1) :
                          (r[0] ? 2'd0 : r[1] ? 2'd1 : 2'd2);
    state_nx = state == IDLE  ? (any ? GRANT : IDLE) :
               state == GRANT ? HOLD :
               cnt != 8'd0    ? HOLD :
               any            ? GRANT : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      win   <= 2'd0;
      last  <= 2'd2;
      cnt   <= 8'd0;
      out_r <= 8'h00;
    end else begin
      state <= state_nx;
      if (state != GRANT && state_nx == GRANT) win <= pick;
      if (state == GRANT) begin
        out_r <= data;
        cnt   <= 8'(DWELL - 1);
        last  <= win;
      end else if (state == HOLD && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
    end
  end
  assign bus.gnt_b     = state == GRANT && win == 2'd0;
  assign bus.gnt_c     = state == GRANT && win == 2'd1;
  assign bus.gnt_d     = state == GRANT && win == 2'd2;
  assign bus.s1        = state != IDLE && win == 2'd1;
  assign bus.s2        = state != IDLE && win == 2'd2;
  assign bus.busy      = state != IDLE;
  assign bus.out_valid = state == HOLD;
  assign bus.out       = out_r;
endmodule
